// File: rtl/car_park_ctrl_pkg.sv
// car_park_pkg: gate state encodings plus sizing and fee-saturation helpers shared by the car park blocks
package car_park_pkg;
  typedef enum logic [1:0] {E_IDLE, E_ALLOC, E_OPEN} entry_state_e;
  typedef enum logic [1:0] {X_IDLE, X_CALC, X_WAIT_PAY, X_OPEN} exit_state_e;
  function automatic int id_w(input int cap);
    return cap > 1 ? $clog2(cap) : 1;
  endfunction
  function automatic int cnt_w(input int cap);
    return $clog2(cap + 1);
  endfunction
  function automatic logic [63:0] sat_fee(input logic [63:0] v, input int fee_w);
    return (v >> fee_w) != 64'd0 ? (64'd1 << fee_w) - 64'd1 : v;
  endfunction
endpackage

// File: rtl/car_park_ctrl_bar_timer.sv
// bar_timer: holds a bar open for exactly BAR_CYCLES cycles starting the cycle after a start pulse
module bar_timer #(
  parameter int BAR_CYCLES = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic open
);
  localparam int W = $clog2(BAR_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic open_d;
  always_comb begin
    open_d = start | (open & (cnt_q != '0));
    cnt_d = start ? W'(BAR_CYCLES - 1) : (open && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      open <= 1'b0;
      cnt_q <= '0;
    end else begin
      open <= open_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/car_park_ctrl.sv
// car_park_ctrl: multi-space car park with concurrent entry/exit gates, timestamped tickets and duration fees
module car_park_ctrl
  import car_park_pkg::*;
#(
  parameter int  CAPACITY   = 5,
  parameter int  TIME_W     = 16,
  parameter int  BAR_CYCLES = 5000,
  parameter int  UNIT_LOG2  = 10,
  parameter int  RATE       = 1,
  parameter int  FEE_W      = 16,
  localparam int ID_W       = id_w(CAPACITY),
  localparam int CNT_W      = cnt_w(CAPACITY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in,
  input  logic             s_out,
  input  logic [ID_W-1:0]  ticket_in,
  input  logic             pay,
  output logic             bin,
  output logic             bout,
  output logic [ID_W-1:0]  ticket_out,
  output logic             ticket_vld,
  output logic [FEE_W-1:0] cost,
  output logic             cost_vld,
  output logic [CNT_W-1:0] free,
  output logic             full,
  output logic             bad_ticket
);
  entry_state_e e_q, e_d;
  exit_state_e x_q, x_d;
  logic [TIME_W-1:0] t_q, dur, units;
  logic [TIME_W-1:0] ts_q [CAPACITY];
  logic [CAPACITY-1:0] occ_q, occ_d;
  logic [2**ID_W-1:0] occ_pad;
  logic [ID_W-1:0] pe, id_q, tkt_q;
  logic [FEE_W-1:0] cost_q;
  logic [CNT_W-1:0] free_q, free_d;
  logic [63:0] prod;
  logic e_go, x_go, tkt_ok, alloc, rel, tkt_vld_q, cost_vld_q, full_q, bad_q;
  always_comb begin
    pe = '0;
    for (int i = CAPACITY - 1; i >= 0; i--) if (!occ_q[i]) pe = ID_W'(i);
    // zero-padded view makes out-of-range ticket ids read as unoccupied
    occ_pad = '0;
    occ_pad[CAPACITY-1:0] = occ_q;
    tkt_ok = occ_pad[ticket_in];
    e_go = e_q == E_IDLE && s_in && !full_q;
    x_go = x_q == X_IDLE && s_out;
    alloc = e_q == E_ALLOC;
    rel = x_q == X_WAIT_PAY && pay;
    e_d = e_go ? E_ALLOC : alloc ? E_OPEN : (e_q == E_OPEN && !bin) ? E_IDLE : e_q;
    x_d = (x_go && tkt_ok) ? X_CALC : (x_q == X_CALC) ? X_WAIT_PAY : rel ? X_OPEN :
          (x_q == X_OPEN && !bout) ? X_IDLE : x_q;
    occ_d = occ_q;
    if (alloc) occ_d[tkt_q] = 1'b1;
    if (rel) occ_d[id_q] = 1'b0;
    free_d = free_q + CNT_W'(rel) - CNT_W'(alloc);
    dur = t_q - ts_q[id_q];
    units = (dur >> UNIT_LOG2) + TIME_W'(|dur[UNIT_LOG2-1:0]);
    prod = 64'(units) * 64'(RATE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q <= E_IDLE;
      x_q <= X_IDLE;
      t_q <= '0;
      occ_q <= '0;
      for (int i = 0; i < CAPACITY; i++) ts_q[i] <= '0;
      id_q <= '0;
      tkt_q <= '0;
      tkt_vld_q <= 1'b0;
      cost_q <= '0;
      cost_vld_q <= 1'b0;
      free_q <= CNT_W'(CAPACITY);
      full_q <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      e_q <= e_d;
      x_q <= x_d;
      t_q <= t_q + TIME_W'(1);
      occ_q <= occ_d;
      if (alloc) ts_q[tkt_q] <= t_q;
      if (x_go) id_q <= ticket_in;
      if (e_go) tkt_q <= pe;
      tkt_vld_q <= e_go;
      if (x_q == X_CALC) cost_q <= FEE_W'(sat_fee(prod, FEE_W));
      cost_vld_q <= x_q == X_CALC || (x_q == X_WAIT_PAY && !pay);
      free_q <= free_d;
      full_q <= free_d == '0;
      bad_q <= x_go && !tkt_ok;
    end
  end
  bar_timer #(.BAR_CYCLES(BAR_CYCLES)) u_bin (.clk(clk), .rst(rst), .start(alloc), .open(bin));
  bar_timer #(.BAR_CYCLES(BAR_CYCLES)) u_bout (.clk(clk), .rst(rst), .start(rel), .open(bout));
  assign ticket_out = tkt_q;
  assign ticket_vld = tkt_vld_q;
  assign cost = cost_q;
  assign cost_vld = cost_vld_q;
  assign free = free_q;
  assign full = full_q;
  assign bad_ticket = bad_q;
endmodule

// File: tb/tb_car_park_ctrl.sv
// tb_car_park_ctrl: scoreboard bench driving an FEE_W=8 and an FEE_W=4 instance with identical stimulus
module tb_car_park_ctrl;
  logic clk = 1'b0, rst = 1'b1, s_in = 1'b0, s_out = 1'b0, pay = 1'b0, cv_prev = 1'b0;
  logic [0:0] ticket_in = 1'b0;
  logic [1:0] bin_w, bout_w, tv_w, cv_w, bad_w, full_w, tk_w;
  logic [1:0] free0, free1;
  logic [7:0] cost0, tb_t;
  logic [3:0] cost1;
  int n_tests = 0, n_fail = 0;
  int exp_tk[$], exp_c[$], exp_cs[$];
  int bin_len[2] = '{0, 0}, bout_len[2] = '{0, 0}, bad_cnt[2] = '{0, 0};
  int ta, ta1;

  car_park_ctrl #(.CAPACITY(2), .TIME_W(8), .BAR_CYCLES(4), .UNIT_LOG2(2), .RATE(3), .FEE_W(8)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_out(s_out), .ticket_in(ticket_in), .pay(pay),
    .bin(bin_w[0]), .bout(bout_w[0]), .ticket_out(tk_w[0]), .ticket_vld(tv_w[0]), .cost(cost0),
    .cost_vld(cv_w[0]), .free(free0), .full(full_w[0]), .bad_ticket(bad_w[0]));
  car_park_ctrl #(.CAPACITY(2), .TIME_W(8), .BAR_CYCLES(4), .UNIT_LOG2(2), .RATE(3), .FEE_W(4)) dut_s (
    .clk(clk), .rst(rst), .s_in(s_in), .s_out(s_out), .ticket_in(ticket_in), .pay(pay),
    .bin(bin_w[1]), .bout(bout_w[1]), .ticket_out(tk_w[1]), .ticket_vld(tv_w[1]), .cost(cost1),
    .cost_vld(cv_w[1]), .free(free1), .full(full_w[1]), .bad_ticket(bad_w[1]));

  always #5 clk = ~clk;
  always @(posedge clk) tb_t <= rst ? 8'd0 : tb_t + 8'd1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at T=%0d", tag, got, exp, tb_t);
    end
  endtask

  function automatic int fee(input int dur);
    return ((dur >> 2) + ((dur & 3) != 0 ? 1 : 0)) * 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_t(input int v);
    for (int i = 0; i < 600 && int'(tb_t) != v; i++) step();
  endtask

  task automatic enter(input int id, output int t_alloc);
    s_in = 1'b1;
    t_alloc = (int'(tb_t) + 1) % 256;
    exp_tk.push_back(id);
    step();
    s_in = 1'b0;
  endtask

  task automatic exit_car(input int id, input int t_alloc);
    int c;
    c = fee((int'(tb_t) + 1 - t_alloc + 256) % 256);
    exp_c.push_back(c);
    exp_cs.push_back(c > 15 ? 15 : c);
    ticket_in = id[0:0];
    s_out = 1'b1;
    step();
    s_out = 1'b0;
  endtask

  task automatic pay_pulse();
    pay = 1'b1;
    step();
    pay = 1'b0;
  endtask

  task automatic check_state(input int f, input int fl);
    chk("free", free0, f);
    chk("free_s", free1, f);
    chk("full", full_w[0], fl);
    chk("full_s", full_w[1], fl);
  endtask

  task automatic reset_chk();
    rst = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      chk("rst_bin", bin_w[k], 0);
      chk("rst_bout", bout_w[k], 0);
      chk("rst_tvld", tv_w[k], 0);
      chk("rst_cvld", cv_w[k], 0);
      chk("rst_bad", bad_w[k], 0);
      chk("rst_tkt", tk_w[k], 0);
    end
    check_state(2, 0);
    chk("rst_cost", cost0, 0);
    chk("rst_cost_s", cost1, 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    int e, cs;
    if (tv_w[0]) begin
      if (exp_tk.size() == 0) chk("tkt_unexpected", 1, 0);
      else begin
        e = exp_tk.pop_front();
        chk("ticket", tk_w[0], e);
        chk("ticket_s", tk_w[1], e);
        chk("tvld_s", tv_w[1], 1);
      end
    end
    if (cv_w[0] && !cv_prev) begin
      if (exp_c.size() == 0) chk("cost_unexpected", 1, 0);
      else begin
        e = exp_c.pop_front();
        cs = exp_cs.pop_front();
        chk("cost", cost0, e);
        chk("cost_sat", cost1, cs);
        chk("cvld_s", cv_w[1], 1);
      end
    end
    cv_prev = cv_w[0];
    for (int k = 0; k < 2; k++) begin
      if (bin_w[k]) bin_len[k]++;
      else if (bin_len[k] != 0) begin
        chk("bin_len", bin_len[k], 4);
        bin_len[k] = 0;
      end
      if (bout_w[k]) bout_len[k]++;
      else if (bout_len[k] != 0) begin
        chk("bout_len", bout_len[k], 4);
        bout_len[k] = 0;
      end
      bad_cnt[k] += int'(bad_w[k]);
    end
  end

  initial begin
    reset_chk();
    // single car: alloc at T=10, calc at T=19
    wait_t(9);
    enter(0, ta);
    wait_t(11);
    check_state(1, 0);
    wait_t(18);
    exit_car(0, ta);
    wait_t(22);
    pay_pulse();
    check_state(2, 0);
    chk("bout_open", bout_w[0], 1);
    steps(6);
    // fill the lot, third car waits for a payment
    enter(0, ta);
    steps(8);
    enter(1, ta1);
    step();
    check_state(0, 1);
    steps(6);
    s_in = 1'b1;
    steps(4);
    chk("bin_held", bin_w[0], 0);
    chk("tvld_held", tv_w[0], 0);
    exit_car(0, ta);
    step();
    exp_tk.push_back(0);
    pay_pulse();
    check_state(1, 0);
    chk("tvld_early", tv_w[0], 0);
    step();
    chk("tvld_after_free", tv_w[0], 1);
    s_in = 1'b0;
    steps(8);
    // wrap-around plus a bad ticket
    reset_chk();
    wait_t(249);
    enter(0, ta);
    wait_t(0);
    ticket_in = 1'b1;
    s_out = 1'b1;
    step();
    s_out = 1'b0;
    chk("bad_pulse", bad_w[0], 1);
    chk("bad_pulse_s", bad_w[1], 1);
    check_state(1, 0);
    wait_t(3);
    chk("bad_stays_idle", cv_w[0], 0);
    wait_t(4);
    exit_car(0, ta);
    wait_t(7);
    pay_pulse();
    steps(6);
    // 255-cycle stay: 192 unsaturated, 15 at FEE_W=4
    reset_chk();
    wait_t(9);
    enter(0, ta);
    steps(2);
    wait_t(8);
    exit_car(0, ta);
    steps(2);
    pay_pulse();
    steps(6);
    // allocation and payment in the same cycle, then reset in WAIT_PAY
    enter(0, ta);
    steps(6);
    exit_car(0, ta);
    step();
    enter(1, ta1);
    pay_pulse();
    check_state(1, 0);
    step();
    check_state(1, 0);
    steps(6);
    exit_car(1, ta1);
    step();
    chk("cvld_wait", cv_w[0], 1);
    reset_chk();
    ticket_in = 1'b1;
    s_out = 1'b1;
    step();
    s_out = 1'b0;
    chk("discarded_tkt", bad_w[0], 1);
    steps(3);
    chk("tk_left", exp_tk.size(), 0);
    chk("cost_left", exp_c.size(), 0);
    chk("bad_cnt", bad_cnt[0], 2);
    chk("bad_cnt_s", bad_cnt[1], 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
